// File: rtl/rx_pkt_buf_pkg.sv
// rx_pkt_buf_pkg
// Shared definitions for the receive packet buffer:
//   - write-side FSM state encoding
//   - DOUT flag bit positions ({first, last, data[15:0]})
//   - statistics/word counter width and a saturating increment helper
package rx_pkt_buf_pkg;

  typedef enum logic [1:0] {
    W_IDLE     = 2'd0,
    W_FILL     = 2'd1,
    W_WAIT_CRC = 2'd2,
    W_DISCARD  = 2'd3
  } w_state_t;

  localparam int FIRST_BIT = 17;
  localparam int LAST_BIT  = 16;
  localparam int DOUT_W    = 18;
  localparam int CNT_W     = 16;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rx_pkt_buf_dpram.sv
// rx_pkt_buf_dpram
// Simple dual-port RAM: one write port, one read port, 1-cycle synchronous
// read. The read output holds its value while i_re is low. No reset.
// Ports:
//   i_clk            clock
//   i_we/i_waddr/i_wdata  write port
//   i_re/i_raddr     read request; o_rdata valid the cycle after i_re
//   o_rdata          registered read data
module rx_pkt_buf_dpram
  import rx_pkt_buf_pkg::*;
#(
  parameter int AW = 11,
  parameter int DW = DOUT_W
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/rx_pkt_buffer.sv
// rx_pkt_buffer
// Packet buffer behind the DCFEB receive frame processor. Frame words are
// written into a circular RAM and stay uncommitted until the CRC verdict;
// good packets are committed, everything else is rolled back. Committed
// packets are streamed out first-word-fall-through with first/last flags.
// Ports:
//   CLK, RST_N           clock, asynchronous active-low reset
//   FRM_DATA[15:0]       frame word, qualified by FRM_DATA_VALID
//   GOOD_CRC, CRC_CHK_VLD CRC verdict and its one-cycle strobe
//   FF_FULL, FF_AF       back-pressure to the frame processor (registered)
//   RD_EN                consume the current DOUT word
//   DOUT[17:0]           {first, last, data}, DOUT_VALID qualifies it
//   PKT_CNT              committed packets not yet fully read
//   BAD_CRC_CNT          packets dropped for bad CRC (saturating)
//   DROP_CNT             packets dropped for overflow/oversize/timeout
//   DBG_WSTATE           current write-FSM state
module rx_pkt_buffer
  import rx_pkt_buf_pkg::*;
#(
  parameter int ADDR_WIDTH    = 11,
  parameter int MAX_PKT_WORDS = 812,
  parameter int CRC_TIMEOUT   = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [15:0]           FRM_DATA,
  input  logic                  FRM_DATA_VALID,
  input  logic                  GOOD_CRC,
  input  logic                  CRC_CHK_VLD,
  output logic                  FF_FULL,
  output logic                  FF_AF,
  input  logic                  RD_EN,
  output logic [DOUT_W-1:0]     DOUT,
  output logic                  DOUT_VALID,
  output logic [ADDR_WIDTH-1:0] PKT_CNT,
  output logic [CNT_W-1:0]      BAD_CRC_CNT,
  output logic [CNT_W-1:0]      DROP_CNT,
  output logic [1:0]            DBG_WSTATE
);

  localparam logic [CNT_W-1:0]      MAX_CNT = CNT_W'(MAX_PKT_WORDS);
  localparam logic [CNT_W-1:0]      TMO_CNT = CNT_W'(CRC_TIMEOUT);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  // Pointers: write, end of last committed packet, consume (read) and the
  // RAM fetch pointer of the prefetch pipeline. rd <= fetch <= cmt <= wr.
  logic [ADDR_WIDTH-1:0] r_wr_ptr, r_cmt_ptr, r_rd_ptr, r_fetch_ptr;
  logic [ADDR_WIDTH-1:0] w_used, w_free;
  logic                  w_free_zero;

  w_state_t         r_wstate, w_wstate_nxt;
  logic [15:0]      r_stg_data;
  logic             r_stg_first;
  logic [CNT_W-1:0] r_word_cnt, r_timer;
  logic [CNT_W-1:0] r_bad_cnt, r_drop_cnt;
  logic [ADDR_WIDTH-1:0] r_pkt_cnt;
  logic             r_ff_full, r_ff_af;
  logic             w_cnt_ovf, w_tmo;

  // Write-side controls from the FSM output process.
  logic                  w_we, w_wr_inc, w_commit, w_rollback;
  logic                  w_bad_inc, w_drop_inc;
  logic                  w_stage_ld, w_stage_first, w_cnt_rst, w_cnt_inc, w_timer_rst;
  logic [DOUT_W-1:0]     w_wdata;
  logic [ADDR_WIDTH-1:0] w_cmt_val;

  // Read side.
  logic [DOUT_W-1:0] w_ram_q;
  logic [DOUT_W-1:0] r_dout;
  logic              r_dout_vld, r_q_vld;
  logic              w_rd_fire, w_s2_take, w_s1_free, w_ren, w_last_rd;

  assign w_used      = r_wr_ptr - r_rd_ptr;
  assign w_free      = {ADDR_WIDTH{1'b1}} - w_used;
  assign w_free_zero = (w_free == '0);
  // Word count already includes the staged word; one more would exceed max.
  assign w_cnt_ovf   = (r_word_cnt >= MAX_CNT);
  assign w_tmo       = (r_timer == TMO_CNT);

  // ---------------- write FSM: state register ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  // ---------------- write FSM: next state ----------------
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (FRM_DATA_VALID) w_wstate_nxt = W_FILL;
      end
      W_FILL: begin
        if (FRM_DATA_VALID) begin
          if (w_free_zero || w_cnt_ovf) w_wstate_nxt = W_DISCARD;
        end else if (w_free_zero || CRC_CHK_VLD) begin
          w_wstate_nxt = W_IDLE;
        end else begin
          w_wstate_nxt = W_WAIT_CRC;
        end
      end
      W_WAIT_CRC: begin
        if (CRC_CHK_VLD)         w_wstate_nxt = W_IDLE;
        else if (FRM_DATA_VALID) w_wstate_nxt = W_FILL;
        else if (w_tmo)          w_wstate_nxt = W_IDLE;
      end
      W_DISCARD: begin
        if (!FRM_DATA_VALID || CRC_CHK_VLD) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // ---------------- write FSM: outputs ----------------
  always_comb begin
    w_we          = 1'b0;
    w_wr_inc      = 1'b0;
    w_commit      = 1'b0;
    w_rollback    = 1'b0;
    w_bad_inc     = 1'b0;
    w_drop_inc    = 1'b0;
    w_stage_ld    = 1'b0;
    w_stage_first = 1'b0;
    w_cnt_rst     = 1'b0;
    w_cnt_inc     = 1'b0;
    w_timer_rst   = 1'b0;
    w_cmt_val     = r_wr_ptr;
    w_wdata                = '0;
    w_wdata[FIRST_BIT]     = r_stg_first;
    w_wdata[15:0]          = r_stg_data;
    case (r_wstate)
      W_IDLE: begin
        if (FRM_DATA_VALID) begin
          w_stage_ld    = 1'b1;
          w_stage_first = 1'b1;
          w_cnt_rst     = 1'b1;
        end
      end
      W_FILL: begin
        if (FRM_DATA_VALID) begin
          // Another word: flush the staged one (not last) unless the packet
          // has run out of room or length, in which case it is abandoned.
          if (!w_free_zero && !w_cnt_ovf) begin
            w_we       = 1'b1;
            w_wr_inc   = 1'b1;
            w_cnt_inc  = 1'b1;
            w_stage_ld = 1'b1;
          end
        end else if (w_free_zero) begin
          w_rollback = 1'b1;
          w_drop_inc = 1'b1;
        end else begin
          // Valid fell: the staged word is the last one.
          w_we              = 1'b1;
          w_wr_inc          = 1'b1;
          w_wdata[LAST_BIT] = 1'b1;
          w_timer_rst       = 1'b1;
          // A verdict in the same cycle applies after the last-word write.
          if (CRC_CHK_VLD && GOOD_CRC) begin
            w_commit  = 1'b1;
            w_cmt_val = r_wr_ptr + PTR_ONE;
          end else if (CRC_CHK_VLD) begin
            w_rollback = 1'b1;
            w_bad_inc  = 1'b1;
          end
        end
      end
      W_WAIT_CRC: begin
        if (CRC_CHK_VLD && GOOD_CRC) begin
          w_commit = 1'b1;
        end else if (CRC_CHK_VLD) begin
          w_rollback = 1'b1;
          w_bad_inc  = 1'b1;
        end else if (FRM_DATA_VALID) begin
          // New frame before any verdict: drop the pending one, start fresh.
          w_rollback    = 1'b1;
          w_drop_inc    = 1'b1;
          w_stage_ld    = 1'b1;
          w_stage_first = 1'b1;
          w_cnt_rst     = 1'b1;
        end else if (w_tmo) begin
          w_rollback = 1'b1;
          w_drop_inc = 1'b1;
        end
      end
      W_DISCARD: begin
        if (!FRM_DATA_VALID || CRC_CHK_VLD) begin
          w_rollback = 1'b1;
          w_drop_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------- write datapath ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr    <= '0;
      r_cmt_ptr   <= '0;
      r_stg_data  <= '0;
      r_stg_first <= 1'b0;
      r_word_cnt  <= '0;
      r_timer     <= '0;
      r_bad_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      // Rollback wins over a same-cycle write: the written word is orphaned.
      if (w_rollback)    r_wr_ptr <= r_cmt_ptr;
      else if (w_wr_inc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_commit) r_cmt_ptr <= w_cmt_val;
      if (w_stage_ld) begin
        r_stg_data  <= FRM_DATA;
        r_stg_first <= w_stage_first;
      end
      if (w_cnt_rst)      r_word_cnt <= CNT_W'(1);
      else if (w_cnt_inc) r_word_cnt <= r_word_cnt + CNT_W'(1);
      if (w_timer_rst)                  r_timer <= '0;
      else if (r_wstate == W_WAIT_CRC)  r_timer <= r_timer + CNT_W'(1);
      if (w_bad_inc)  r_bad_cnt  <= sat_inc(r_bad_cnt);
      if (w_drop_inc) r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  rx_pkt_buf_dpram #(
    .AW (ADDR_WIDTH),
    .DW (DOUT_W)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_re    (w_ren),
    .i_raddr (r_fetch_ptr),
    .o_rdata (w_ram_q)
  );

  // ---------------- read side ----------------
  // Handshake: DOUT/DOUT_VALID are registered. A word is transferred on a
  // rising edge where DOUT_VALID=1 and RD_EN=1; RD_EN with DOUT_VALID=0 is
  // ignored. Two stages feed DOUT: the RAM output register (r_q_vld) and
  // the DOUT register, so a continuous RD_EN drains 1 word/cycle.
  assign w_rd_fire = RD_EN && r_dout_vld;
  assign w_s2_take = !r_dout_vld || w_rd_fire;
  assign w_s1_free = !r_q_vld || w_s2_take;
  assign w_ren     = (r_fetch_ptr != r_cmt_ptr) && w_s1_free;
  assign w_last_rd = w_rd_fire && r_dout[LAST_BIT];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_ptr    <= '0;
      r_fetch_ptr <= '0;
      r_q_vld     <= 1'b0;
      r_dout_vld  <= 1'b0;
      r_dout      <= '0;
      r_pkt_cnt   <= '0;
      r_ff_full   <= 1'b0;
      r_ff_af     <= 1'b0;
    end else begin
      if (w_ren)     r_fetch_ptr <= r_fetch_ptr + PTR_ONE;
      if (w_rd_fire) r_rd_ptr    <= r_rd_ptr + PTR_ONE;
      if (w_ren)          r_q_vld <= 1'b1;
      else if (w_s2_take) r_q_vld <= 1'b0;
      if (w_s2_take) begin
        r_dout_vld <= r_q_vld;
        if (r_q_vld) r_dout <= w_ram_q;
      end
      case ({w_commit, w_last_rd})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + PTR_ONE;
        2'b01:   r_pkt_cnt <= r_pkt_cnt - PTR_ONE;
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
      r_ff_full <= w_free_zero;
      r_ff_af   <= (32'(w_free) < 32'(MAX_PKT_WORDS));
    end
  end

  assign FF_FULL     = r_ff_full;
  assign FF_AF       = r_ff_af;
  assign DOUT        = r_dout;
  assign DOUT_VALID  = r_dout_vld;
  assign PKT_CNT     = r_pkt_cnt;
  assign BAD_CRC_CNT = r_bad_cnt;
  assign DROP_CNT    = r_drop_cnt;
  assign DBG_WSTATE  = r_wstate;

endmodule

// File: tb/tb_rx_pkt_buffer.sv
module tb_rx_pkt_buffer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] frm_data = '0;
  logic        frm_data_valid = 1'b0;
  logic        good_crc = 1'b0;
  logic        crc_chk_vld = 1'b0;
  logic        rd_en = 1'b0;

  // Default-size instance
  logic        b_ff_full, b_ff_af, b_dv;
  logic [17:0] b_dout;
  logic [10:0] b_pkt;
  logic [15:0] b_bad, b_drop;
  logic [1:0]  b_dbg;
  // Small instance (ADDR_WIDTH=6) for the overflow scenario
  logic        s_ff_full, s_ff_af, s_dv;
  logic [17:0] s_dout;
  logic [5:0]  s_pkt;
  logic [15:0] s_bad, s_drop;
  logic [1:0]  s_dbg;

  rx_pkt_buffer u_big (
    .CLK(clk), .RST_N(rst_n), .FRM_DATA(frm_data), .FRM_DATA_VALID(frm_data_valid),
    .GOOD_CRC(good_crc), .CRC_CHK_VLD(crc_chk_vld), .FF_FULL(b_ff_full), .FF_AF(b_ff_af),
    .RD_EN(rd_en), .DOUT(b_dout), .DOUT_VALID(b_dv), .PKT_CNT(b_pkt),
    .BAD_CRC_CNT(b_bad), .DROP_CNT(b_drop), .DBG_WSTATE(b_dbg)
  );

  rx_pkt_buffer #(.ADDR_WIDTH(6)) u_small (
    .CLK(clk), .RST_N(rst_n), .FRM_DATA(frm_data), .FRM_DATA_VALID(frm_data_valid),
    .GOOD_CRC(good_crc), .CRC_CHK_VLD(crc_chk_vld), .FF_FULL(s_ff_full), .FF_AF(s_ff_af),
    .RD_EN(rd_en), .DOUT(s_dout), .DOUT_VALID(s_dv), .PKT_CNT(s_pkt),
    .BAD_CRC_CNT(s_bad), .DROP_CNT(s_drop), .DBG_WSTATE(s_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  logic [17:0] exp_w;
  int   rd_cycles;
  bit   wait_ok;
  bit   sel_small = 1'b0;
  bit   s_full_seen;
  bit   dv_seen;
  logic        m_dv;
  logic [17:0] m_dout;

  always_comb begin
    m_dv   = sel_small ? s_dv : b_dv;
    m_dout = sel_small ? s_dout : b_dout;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    frm_data = '0; frm_data_valid = 0; good_crc = 0; crc_chk_vld = 0; rd_en = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();
  endtask

  // n words: start, start+step, ... then valid falls; optional good CRC on the fall cycle.
  task automatic send_pkt(input int n, input logic [15:0] start, input logic [15:0] step,
                          input bit fall_crc);
    logic [15:0] d;
    d = start;
    for (int i = 0; i < n; i++) begin
      frm_data = d; frm_data_valid = 1;
      if (s_ff_full) s_full_seen = 1;
      tick();
      d = d + step;
    end
    frm_data_valid = 0; frm_data = '0;
    if (fall_crc) begin crc_chk_vld = 1; good_crc = 1; end
    tick();
    crc_chk_vld = 0; good_crc = 0;
  endtask

  task automatic pulse_crc(input bit good);
    crc_chk_vld = 1; good_crc = good;
    tick();
    crc_chk_vld = 0; good_crc = 0;
  endtask

  task automatic wait_dv(input int budget);
    int n;
    n = 0;
    while (!m_dv && n < budget) begin tick(); n++; end
    wait_ok = m_dv;
  endtask

  task automatic read_words(input int n, input int budget);
    got_q.delete();
    rd_cycles = 0;
    rd_en = 1;
    while (got_q.size() < n && rd_cycles < budget) begin
      if (m_dv) got_q.push_back(m_dout);
      tick();
      rd_cycles++;
    end
    rd_en = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    checks++; if (b_dout !== 18'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", b_dout); end
    checks++; if (b_dv !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", b_dv); end
    checks++; if (b_pkt !== 11'd0) begin failures++; $display("FAIL reset_pkt got=%0d exp=0", b_pkt); end
    checks++; if (b_bad !== 16'd0 || b_drop !== 16'd0) begin failures++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", b_bad, b_drop); end
    checks++; if (b_ff_full !== 1'b0 || b_ff_af !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", b_ff_full, b_ff_af); end
    checks++; if (b_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", b_dbg); end
    do_reset();
  endtask

  task automatic test_good_packet();
    do_reset();
    send_pkt(4, 16'h1111, 16'h1111, 0);
    tick(); tick();
    pulse_crc(1);
    checks++; if (b_pkt !== 11'd1) begin failures++; $display("FAIL good_pkt_cnt got=%0d exp=1", b_pkt); end
    checks++; if (b_dv !== 1'b0) begin failures++; $display("FAIL good_dv_lat0 got=%b exp=0", b_dv); end
    tick();
    checks++; if (b_dv !== 1'b0) begin failures++; $display("FAIL good_dv_lat1 got=%b exp=0", b_dv); end
    tick();
    checks++; if (b_dv !== 1'b1) begin failures++; $display("FAIL good_dv_lat2 got=%b exp=1", b_dv); end
    exp_q = '{18'h21111, 18'h02222, 18'h03333, 18'h14444};
    read_words(4, 20);
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL good_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL good_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (rd_cycles != 4) begin failures++; $display("FAIL good_rate got=%0d exp=4", rd_cycles); end
    checks++; if (b_pkt !== 11'd0) begin failures++; $display("FAIL good_pkt_after got=%0d exp=0", b_pkt); end
  endtask

  task automatic test_bad_crc();
    send_pkt(10, 16'h0100, 16'h0001, 0);
    tick();
    pulse_crc(0);
    checks++; if (b_bad !== 16'd1) begin failures++; $display("FAIL bad_cnt got=%0d exp=1", b_bad); end
    checks++; if (b_pkt !== 11'd0) begin failures++; $display("FAIL bad_pkt got=%0d exp=0", b_pkt); end
    dv_seen = 0;
    for (int i = 0; i < 6; i++) begin if (b_dv) dv_seen = 1; tick(); end
    checks++; if (dv_seen) begin failures++; $display("FAIL bad_dv got=1 exp=0"); end
    send_pkt(3, 16'hA000, 16'h0001, 0);
    pulse_crc(1);
    wait_dv(10);
    checks++; if (!wait_ok) begin failures++; $display("FAIL bad_next_wait got=0 exp=1"); end
    exp_q = '{18'h2A000, 18'h0A001, 18'h1A002};
    read_words(3, 20);
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL bad_next_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bad_next_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_pkt(3, 16'h3000, 16'h0001, 0);
    repeat (15) tick();
    checks++; if (b_drop !== 16'd0) begin failures++; $display("FAIL tmo_early got=%0d exp=0", b_drop); end
    repeat (5) tick();
    checks++; if (b_drop !== 16'd1) begin failures++; $display("FAIL tmo_drop got=%0d exp=1", b_drop); end
    checks++; if (b_pkt !== 11'd0 || b_dv !== 1'b0) begin failures++; $display("FAIL tmo_pkt got=%0d/%b exp=0/0", b_pkt, b_dv); end
    checks++; if (b_ff_full !== 1'b0 || b_ff_af !== 1'b0) begin failures++; $display("FAIL tmo_flags got=%b%b exp=00", b_ff_full, b_ff_af); end
    checks++; if (b_dbg !== 2'd0) begin failures++; $display("FAIL tmo_state got=%0d exp=0", b_dbg); end
  endtask

  task automatic test_overflow();
    sel_small = 1;
    do_reset();
    checks++; if (s_ff_af !== 1'b1 || s_ff_full !== 1'b0) begin failures++; $display("FAIL ovf_init_flags got=%b%b exp=01", s_ff_full, s_ff_af); end
    send_pkt(5, 16'h5000, 16'h0001, 0);
    pulse_crc(1);
    checks++; if (s_pkt !== 6'd1) begin failures++; $display("FAIL ovf_first_pkt got=%0d exp=1", s_pkt); end
    s_full_seen = 0;
    send_pkt(70, 16'h7000, 16'h0001, 0);
    checks++; if (!s_full_seen) begin failures++; $display("FAIL ovf_full_seen got=0 exp=1"); end
    checks++; if (s_drop !== 16'd1) begin failures++; $display("FAIL ovf_drop got=%0d exp=1", s_drop); end
    tick(); tick();
    checks++; if (s_ff_full !== 1'b0) begin failures++; $display("FAIL ovf_full_clear got=%b exp=0", s_ff_full); end
    pulse_crc(1);
    checks++; if (s_pkt !== 6'd1 || s_bad !== 16'd0 || s_drop !== 16'd1) begin
      failures++; $display("FAIL ovf_idle_crc got=%0d/%0d/%0d exp=1/0/1", s_pkt, s_bad, s_drop); end
    exp_q = '{18'h25000, 18'h05001, 18'h05002, 18'h05003, 18'h15004};
    read_words(5, 20);
    checks++; if (got_q.size() != 5) begin failures++; $display("FAIL ovf_count got=%0d exp=5", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    sel_small = 0;
  endtask

  task automatic test_oversize();
    do_reset();
    send_pkt(813, 16'h0000, 16'h0001, 0);
    tick();
    pulse_crc(1);
    checks++; if (b_drop !== 16'd1 || b_pkt !== 11'd0 || b_bad !== 16'd0) begin
      failures++; $display("FAIL osz_813 got=drop%0d pkt%0d bad%0d exp=1/0/0", b_drop, b_pkt, b_bad); end
    send_pkt(812, 16'h0000, 16'h0001, 0);
    pulse_crc(1);
    checks++; if (b_pkt !== 11'd1 || b_drop !== 16'd1) begin failures++; $display("FAIL osz_812_commit got=pkt%0d drop%0d exp=1/1", b_pkt, b_drop); end
    wait_dv(10);
    checks++; if (!wait_ok) begin failures++; $display("FAIL osz_wait got=0 exp=1"); end
    read_words(812, 900);
    checks++; if (got_q.size() != 812) begin failures++; $display("FAIL osz_count got=%0d exp=812", got_q.size()); end
    checks++; if (rd_cycles != 812) begin failures++; $display("FAIL osz_rate got=%0d exp=812", rd_cycles); end
    for (int i = 0; i < got_q.size(); i++) begin
      exp_w = {(i == 0), (i == 811), 16'(i)};
      checks++; if (got_q[i] !== exp_w) begin failures++; $display("FAIL osz_word%0d got=%h exp=%h", i, got_q[i], exp_w); end
    end
    checks++; if (b_pkt !== 11'd0) begin failures++; $display("FAIL osz_pkt_after got=%0d exp=0", b_pkt); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    send_pkt(2, 16'hB000, 16'h0001, 1);
    checks++; if (b_pkt !== 11'd1) begin failures++; $display("FAIL sim_fall_commit got=%0d exp=1", b_pkt); end
    wait_dv(10);
    checks++; if (b_dout !== 18'h2B000) begin failures++; $display("FAIL sim_w0 got=%h exp=2b000", b_dout); end
    rd_en = 1; tick(); rd_en = 0;
    checks++; if (b_dv !== 1'b1 || b_dout !== 18'h1B001) begin failures++; $display("FAIL sim_w1 got=%b/%h exp=1/1b001", b_dv, b_dout); end
    send_pkt(3, 16'hC000, 16'h0001, 0);
    rd_en = 1; crc_chk_vld = 1; good_crc = 1;
    tick();
    rd_en = 0; crc_chk_vld = 0; good_crc = 0;
    checks++; if (b_pkt !== 11'd1) begin failures++; $display("FAIL sim_pkt_steady got=%0d exp=1", b_pkt); end
    wait_dv(10);
    exp_q = '{18'h2C000, 18'h0C001, 18'h1C002};
    read_words(3, 20);
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL sim_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL sim_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (b_pkt !== 11'd0) begin failures++; $display("FAIL sim_pkt_after got=%0d exp=0", b_pkt); end
    send_pkt(1, 16'hD00D, 16'h0001, 1);
    wait_dv(10);
    read_words(1, 10);
    checks++; if (got_q.size() != 1 || got_q[0] !== 18'h3D00D) begin
      failures++; $display("FAIL sim_one_word got=%h n=%0d exp=3d00d", (got_q.size() > 0) ? got_q[0] : 18'h0, got_q.size()); end
  endtask

  task automatic test_reset_mid();
    send_pkt(2, 16'hE000, 16'h0001, 0);
    pulse_crc(0);
    send_pkt(2, 16'hF000, 16'h0001, 1);
    wait_dv(10);
    checks++; if (b_bad !== 16'd1 || b_dv !== 1'b1 || b_pkt !== 11'd1) begin
      failures++; $display("FAIL rstm_pre got=bad%0d dv%b pkt%0d exp=1/1/1", b_bad, b_dv, b_pkt); end
    frm_data = 16'h1234; frm_data_valid = 1;
    tick(); tick();
    #2 rst_n = 0;
    #1;
    checks++; if (b_dout !== 18'h0 || b_dv !== 1'b0 || b_pkt !== 11'd0) begin
      failures++; $display("FAIL rstm_out got=%h/%b/%0d exp=0/0/0", b_dout, b_dv, b_pkt); end
    checks++; if (b_bad !== 16'd0 || b_drop !== 16'd0 || b_ff_full !== 1'b0 || b_ff_af !== 1'b0 || b_dbg !== 2'd0) begin
      failures++; $display("FAIL rstm_misc got=%0d/%0d/%b/%b/%0d exp=0", b_bad, b_drop, b_ff_full, b_ff_af, b_dbg); end
    frm_data_valid = 0; frm_data = '0;
    tick();
    rst_n = 1;
    tick();
    send_pkt(2, 16'h4321, 16'h0001, 1);
    wait_dv(10);
    exp_q = '{18'h24321, 18'h14322};
    read_words(2, 10);
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL rstm_count got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rstm_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (b_pkt !== 11'd0 || b_bad !== 16'd0) begin failures++; $display("FAIL rstm_after got=%0d/%0d exp=0/0", b_pkt, b_bad); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_good_packet();
    test_bad_crc();
    test_timeout();
    test_overflow();
    test_oversize();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_pkt_buffer.md
Name: rx_pkt_buffer

Overview:
Packet buffer directly downstream of the DCFEB receive frame processor. It stores each frame's data words in a circular dual-port RAM and holds them uncommitted until the CRC verdict arrives. Good-CRC packets are committed; bad, oversized, timed-out or overflowed packets are rolled back. It presents committed packets to the readout logic as a first-word-fall-through stream with first/last flags, and drives the FF_FULL/FF_AF back-pressure inputs of the frame processor.

Parameters:
ADDR_WIDTH, 11, RAM depth is 2**ADDR_WIDTH words; one slot is always reserved, so usable space is DEPTH-1.
MAX_PKT_WORDS, 812, packets longer than this are discarded; also sets the FF_AF threshold.
CRC_TIMEOUT, 16, maximum number of cycles from the last data word to CRC_CHK_VLD.

Ports:
CLK  in  1  system clock; all logic is on the rising edge.
RST_N  in  1  asynchronous, active-low reset.
FRM_DATA  in  16  frame data word.
FRM_DATA_VALID  in  1  FRM_DATA is a payload word.
GOOD_CRC  in  1  CRC verdict; sampled only when CRC_CHK_VLD=1.
CRC_CHK_VLD  in  1  one-cycle strobe: the CRC verdict is valid.
FF_FULL  out  1  free==0.
FF_AF  out  1  free<MAX_PKT_WORDS.
RD_EN  in  1  consume the DOUT word; ignored when DOUT_VALID=0.
DOUT  out  18  {first,last,data[15:0]}.
DOUT_VALID  out  1  DOUT holds a committed word.
PKT_CNT  out  ADDR_WIDTH  number of committed, unread packets.
BAD_CRC_CNT  out  16  count of packets discarded for bad CRC; saturates.
DROP_CNT  out  16  count of packets discarded for overflow, oversize or timeout; saturates.

Behaviour:
- Reset (async, RST_N=0): all pointers=0, state=W_IDLE, DOUT=0, DOUT_VALID=0, PKT_CNT=0, both counters=0, FF_FULL=0, FF_AF=0.
- Pointers:
  - wr_ptr: next write address.
  - cmt_ptr: end of the last committed packet.
  - rd_ptr: next read address.
  - All pointers wrap modulo 2**ADDR_WIDTH.
  - used=wr_ptr-rd_ptr (modulo arithmetic); free=DEPTH-1-used. FF_FULL and FF_AF are registered from free.
- Staging: each valid word is held one cycle in a staging register. It is written to RAM when the next valid word arrives (last=0), or on the FRM_DATA_VALID falling edge (last=1). first=1 on the first word after W_IDLE. A 1-word packet carries first=1 and last=1.
- Write FSM (encoded in the package):
  - W_IDLE: FRM_DATA_VALID=1 -> W_FILL; stage the word; word count=1.
  - W_FILL:
    - On each valid word, write the staged word; wr_ptr++; count++.
    - If free==0 at a write, or count>MAX_PKT_WORDS -> W_DISCARD; no further writes.
    - On the FRM_DATA_VALID fall, write the staged word with last=1 -> W_WAIT_CRC; timer=0.
  - W_WAIT_CRC:
    - CRC_CHK_VLD&GOOD_CRC: cmt_ptr<=wr_ptr; PKT_CNT++ -> W_IDLE.
    - CRC_CHK_VLD&!GOOD_CRC: wr_ptr<=cmt_ptr; BAD_CRC_CNT++ -> W_IDLE.
    - timer==CRC_TIMEOUT: rollback; DROP_CNT++ -> W_IDLE.
    - FRM_DATA_VALID=1 before any verdict: rollback; DROP_CNT++; stage the word as the first word of a new packet -> W_FILL.
  - W_DISCARD: on the FRM_DATA_VALID fall, or on CRC_CHK_VLD, rollback; DROP_CNT++ -> W_IDLE. The verdict is ignored.
- CRC_CHK_VLD arriving in the same cycle as the FRM_DATA_VALID fall is honoured as if in W_WAIT_CRC, after the last-word write. CRC_CHK_VLD in W_IDLE is ignored.
- Read side: FWFT with a one-word prefetch register fed by the synchronous RAM.
  - DOUT_VALID asserts 2 cycles after the commit edge when PKT_CNT was 0.
  - With RD_EN&DOUT_VALID, the next word appears the following cycle while committed words remain, so back-to-back reads run at 1 word/cycle.
  - The reader never passes cmt_ptr; uncommitted words are never visible.
  - Reading a word with last=1 decrements PKT_CNT. A simultaneous commit and last-read leaves PKT_CNT unchanged.
- Rollback never moves wr_ptr behind rd_ptr, because rd_ptr≤cmt_ptr.

Decomposition:
- Package rx_pkt_buf_pkg:
  - write-state encoding: W_IDLE, W_FILL, W_WAIT_CRC, W_DISCARD;
  - DOUT flag bit positions: FIRST_BIT=17, LAST_BIT=16;
  - counter width constant 16.
- Sub-module rx_pkt_buf_dpram: simple dual-port RAM, 18 bits wide, 1-cycle synchronous read, one write port and one read port, no reset.

Test Plan:
- Good packet: 4 words 0x1111..0x4444, then CRC_CHK_VLD=1, GOOD_CRC=1 3 cycles later -> PKT_CNT=1. DOUT sequence 0x21111, 0x02222, 0x03333, 0x14444 with RD_EN held high; PKT_CNT=0 after the last read.
- Bad CRC: 10-word packet with GOOD_CRC=0 -> BAD_CRC_CNT=1, PKT_CNT=0, DOUT_VALID never asserts. A following good packet reads out intact starting at the old cmt_ptr.
- Timeout: 3-word packet with no CRC_CHK_VLD -> rollback CRC_TIMEOUT=16 cycles after the fall; DROP_CNT=1; FF_AF/FF_FULL return to their pre-packet values.
- Overflow: ADDR_WIDTH=6, no reads, 70-word packet -> FF_FULL=1 at free=0; packet dropped; DROP_CNT=1; earlier committed packets remain readable.
- Oversize: 813-word packet with a good CRC -> discarded; DROP_CNT=1; PKT_CNT unchanged. An 812-word packet commits.
- Simultaneous events and reset: last-word read coinciding with a commit -> PKT_CNT steady at 1. RST_N low mid-packet -> all outputs 0 immediately; the next packet is handled normally.
